// File: rtl/mig_rw_arbiter.sv
// Round-robin arbiter sharing one MIG user command port between a write and a read burst controller.
// Define MIG_ARB_RD_PRIORITY_EN to give reads fixed priority on simultaneous requests.
module mig_rw_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 16
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic              init_calib_complete,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  wr_req_len,
    input  logic [LEN_W-1:0]  rd_req_len,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              wr_done,
    output logic              rd_done,
    output logic              wr_start,
    output logic              rd_start,
    output logic [ADDR_W-1:0] wr_start_addr,
    output logic [ADDR_W-1:0] rd_start_addr,
    output logic [LEN_W-1:0]  wr_start_len,
    output logic [LEN_W-1:0]  rd_start_len,
    input  logic              wr_ctrl_done,
    input  logic              rd_ctrl_done,
    input  logic [ADDR_W-1:0] wr_app_addr,
    input  logic [ADDR_W-1:0] rd_app_addr,
    input  logic [2:0]        wr_app_cmd,
    input  logic [2:0]        rd_app_cmd,
    input  logic              wr_app_en,
    input  logic              rd_app_en,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rd_data_valid,
    output logic              busy,
    output logic              stray_rd_err
);

    typedef enum logic [1:0] {IDLE, WR_RUN, RD_RUN, RD_DRAIN} state_t;
    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              pick_rd, can_grant;
    logic              grant_wr, grant_rd;
    logic              wr_done_nxt, rd_done_nxt;
    logic              wr_zero_pend, rd_zero_pend;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W:0]    beat_sum;
    logic              beats_all;
    logic              rd_active;
    logic [ADDR_W-1:0] addr_hold;
    logic [2:0]        cmd_hold;

    // Beats counted including the one arriving this cycle, compared against the latched length.
    assign beat_sum  = {1'b0, beat_cnt} + {{LEN_W{1'b0}}, app_rd_data_valid};
    assign beats_all = (beat_sum == {1'b0, rd_start_len});
    assign rd_active = (state == RD_RUN) || (state == RD_DRAIN);
    assign busy      = (state != IDLE);

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        wr_done_nxt = 1'b0;
        rd_done_nxt = 1'b0;
        app_en      = 1'b0;
        app_addr    = addr_hold;
        app_cmd     = cmd_hold;
`ifdef MIG_ARB_RD_PRIORITY_EN
        pick_rd     = rd_req;
`else
        pick_rd     = rd_req && (!wr_req || (last_grant == GRANT_WR));
`endif
        // The cycle after a grant the client still holds its request; block re-granting it.
        can_grant   = init_calib_complete && !wr_ack && !rd_ack;
        case (state)
            IDLE: begin
                if (can_grant) begin
                    if (pick_rd) begin
                        grant_rd = 1'b1;
                        if (rd_req_len != '0) state_nxt = RD_RUN;
                    end else if (wr_req) begin
                        grant_wr = 1'b1;
                        if (wr_req_len != '0) state_nxt = WR_RUN;
                    end
                end
            end
            WR_RUN: begin
                app_en   = wr_app_en;
                app_addr = wr_app_addr;
                app_cmd  = wr_app_cmd;
                if (wr_ctrl_done) begin
                    state_nxt   = IDLE;
                    wr_done_nxt = 1'b1;
                end
            end
            RD_RUN: begin
                app_en   = rd_app_en;
                app_addr = rd_app_addr;
                app_cmd  = rd_app_cmd;
                if (rd_ctrl_done) begin
                    if (beats_all) begin
                        state_nxt   = IDLE;
                        rd_done_nxt = 1'b1;
                    end else begin
                        state_nxt = RD_DRAIN;
                    end
                end
            end
            RD_DRAIN: begin
                app_cmd = 3'b001;
                if (beats_all) begin
                    state_nxt   = IDLE;
                    rd_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            last_grant    <= GRANT_RD;
            wr_ack        <= 1'b0;
            rd_ack        <= 1'b0;
            wr_start      <= 1'b0;
            rd_start      <= 1'b0;
            wr_done       <= 1'b0;
            rd_done       <= 1'b0;
            wr_zero_pend  <= 1'b0;
            rd_zero_pend  <= 1'b0;
            wr_start_addr <= '0;
            rd_start_addr <= '0;
            wr_start_len  <= '0;
            rd_start_len  <= '0;
            beat_cnt      <= '0;
            stray_rd_err  <= 1'b0;
            addr_hold     <= '0;
            cmd_hold      <= 3'b000;
        end else begin
            wr_ack       <= grant_wr;
            rd_ack       <= grant_rd;
            wr_start     <= grant_wr && (wr_req_len != '0);
            rd_start     <= grant_rd && (rd_req_len != '0);
            wr_zero_pend <= grant_wr && (wr_req_len == '0);
            rd_zero_pend <= grant_rd && (rd_req_len == '0);
            wr_done      <= wr_done_nxt || wr_zero_pend;
            rd_done      <= rd_done_nxt || rd_zero_pend;
            addr_hold    <= app_addr;
            cmd_hold     <= app_cmd;
            if (grant_wr) begin
                wr_start_addr <= wr_req_addr;
                wr_start_len  <= wr_req_len;
                last_grant    <= GRANT_WR;
            end
            if (grant_rd) begin
                rd_start_addr <= rd_req_addr;
                rd_start_len  <= rd_req_len;
                last_grant    <= GRANT_RD;
                beat_cnt      <= '0;
            end else if (app_rd_data_valid && rd_active) begin
                beat_cnt <= beat_sum[LEN_W-1:0];
            end
            if (app_rd_data_valid && !rd_active) stray_rd_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mig_rw_arbiter.sv
// Directed self-checking bench for mig_rw_arbiter: calibration gating, arbitration order,
// read drain, zero-length requests, mid-burst reset and stray read beats.
module tb_mig_rw_arbiter;
    localparam int ADDR_W = 28;
    localparam int LEN_W  = 16;

    logic              ui_clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_calib_complete = 1'b0;
    logic              wr_req = 1'b0, rd_req = 1'b0;
    logic [ADDR_W-1:0] wr_req_addr = '0, rd_req_addr = '0;
    logic [LEN_W-1:0]  wr_req_len = '0, rd_req_len = '0;
    logic              wr_ack, rd_ack, wr_done, rd_done, wr_start, rd_start;
    logic [ADDR_W-1:0] wr_start_addr, rd_start_addr;
    logic [LEN_W-1:0]  wr_start_len, rd_start_len;
    logic              wr_ctrl_done = 1'b0, rd_ctrl_done = 1'b0;
    logic [ADDR_W-1:0] wr_app_addr = '0, rd_app_addr = '0;
    logic [2:0]        wr_app_cmd = '0, rd_app_cmd = '0;
    logic              wr_app_en = 1'b0, rd_app_en = 1'b0;
    logic [ADDR_W-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rd_data_valid = 1'b0;
    logic              busy, stray_rd_err;

    int   n_checks = 0;
    int   n_errors = 0;
    logic gw, gr, early;
    int   nw, nr;
    logic exp_rd [6];

    always #5 ui_clk = ~ui_clk;

    mig_rw_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .wr_req(wr_req), .rd_req(rd_req),
        .wr_req_addr(wr_req_addr), .rd_req_addr(rd_req_addr),
        .wr_req_len(wr_req_len), .rd_req_len(rd_req_len),
        .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_done(wr_done), .rd_done(rd_done),
        .wr_start(wr_start), .rd_start(rd_start),
        .wr_start_addr(wr_start_addr), .rd_start_addr(rd_start_addr),
        .wr_start_len(wr_start_len), .rd_start_len(rd_start_len),
        .wr_ctrl_done(wr_ctrl_done), .rd_ctrl_done(rd_ctrl_done),
        .wr_app_addr(wr_app_addr), .rd_app_addr(rd_app_addr),
        .wr_app_cmd(wr_app_cmd), .rd_app_cmd(rd_app_cmd),
        .wr_app_en(wr_app_en), .rd_app_en(rd_app_en),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_rd_data_valid(app_rd_data_valid),
        .busy(busy), .stray_rd_err(stray_rd_err)
    );

    task automatic step();
        @(posedge ui_clk);
        #2;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_ack(output logic got_w, output logic got_r);
        got_w = 1'b0;
        got_r = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (wr_ack || rd_ack) begin
                got_w = wr_ack;
                got_r = rd_ack;
                break;
            end
        end
        check_val("ack_seen", {31'd0, got_w | got_r}, 32'd1);
    endtask

    task automatic run_wr_burst(input logic [ADDR_W-1:0] addr);
        wr_app_en = 1'b1; wr_app_addr = addr; wr_app_cmd = 3'b000;
        rd_app_en = 1'b1; rd_app_addr = 28'hBAD0; rd_app_cmd = 3'b001;
        #1;
        check_val("wr_app_en", app_en, 1);
        check_val("wr_app_addr", app_addr, addr);
        check_val("wr_app_cmd", app_cmd, 0);
        step();
        wr_ctrl_done = 1'b1;
        step();
        wr_ctrl_done = 1'b0;
        check_val("wr_done", wr_done, 1);
        check_val("idle_gap_wr", busy, 0);
        check_val("idle_app_en_wr", app_en, 0);
        wr_app_en = 1'b0; rd_app_en = 1'b0;
    endtask

    task automatic run_rd_burst(input int n);
        rd_app_en = 1'b1; rd_app_addr = 28'h2000; rd_app_cmd = 3'b001;
        wr_app_en = 1'b1; wr_app_addr = 28'hBAD0; wr_app_cmd = 3'b000;
        #1;
        check_val("rd_app_en", app_en, 1);
        check_val("rd_app_addr", app_addr, 28'h2000);
        app_rd_data_valid = 1'b1;
        repeat (n) step();
        app_rd_data_valid = 1'b0;
        rd_ctrl_done = 1'b1;
        step();
        rd_ctrl_done = 1'b0;
        check_val("rd_done", rd_done, 1);
        check_val("idle_gap_rd", busy, 0);
        check_val("idle_app_en_rd", app_en, 0);
        wr_app_en = 1'b0; rd_app_en = 1'b0;
    endtask

    initial begin
`ifdef MIG_ARB_RD_PRIORITY_EN
        exp_rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        exp_rd = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        step();
        check_val("rst_busy", busy, 0);
        check_val("rst_wr_ack", wr_ack, 0);
        check_val("rst_app_en", app_en, 0);
        check_val("rst_app_cmd", app_cmd, 0);
        check_val("rst_stray", stray_rd_err, 0);
        check_val("rst_wr_start_addr", wr_start_addr, 0);
        rst = 1'b0;
        step();

        // Calibration gating
        wr_req = 1'b1; wr_req_addr = 28'h0000100; wr_req_len = 16'd64;
        early = 1'b0;
        repeat (20) begin
            step();
            if (wr_ack) early = 1'b1;
        end
        check_val("no_ack_wo_calib", early, 0);
        init_calib_complete = 1'b1;
        step();
        check_val("calib_wr_ack", wr_ack, 1);
        check_val("calib_wr_start", wr_start, 1);
        check_val("calib_start_addr", wr_start_addr, 28'h0000100);
        check_val("calib_start_len", wr_start_len, 64);
        check_val("calib_busy", busy, 1);
        wr_req = 1'b0;
        run_wr_burst(28'h0000100);
        wr_app_addr = 28'h0000FFF;
        #1;
        check_val("idle_addr_hold", app_addr, 28'h0000100);

        // Simultaneous requests from reset
        do_reset();
        wr_req_len = 16'd8; rd_req_len = 16'd8;
        wr_req_addr = 28'h1000; rd_req_addr = 28'h2000;
        wr_req = 1'b1; rd_req = 1'b1;
        nw = 0; nr = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ack(gw, gr);
            check_val("grant_order", {31'd0, gr}, {31'd0, exp_rd[i]});
            if (gr) begin
                nr++;
                if (nr == 3) rd_req = 1'b0;
                run_rd_burst(8);
            end else if (gw) begin
                nw++;
                if (nw == 3) wr_req = 1'b0;
                run_wr_burst(28'h1000);
            end
        end
        wr_req = 1'b0; rd_req = 1'b0;

        // Read drain with queued write
        rd_req = 1'b1; rd_req_len = 16'd16; rd_req_addr = 28'h300;
        wait_ack(gw, gr);
        rd_req = 1'b0;
        check_val("drain_rd_start", rd_start, 1);
        check_val("drain_rd_len", rd_start_len, 16);
        rd_app_en = 1'b1; rd_app_cmd = 3'b001; rd_app_addr = 28'h300;
        app_rd_data_valid = 1'b1;
        repeat (9) step();
        rd_ctrl_done = 1'b1;
        step();
        rd_ctrl_done = 1'b0;
        app_rd_data_valid = 1'b0;
        rd_app_cmd = 3'b111;
        wr_req = 1'b1; wr_req_len = 16'd8; wr_req_addr = 28'h400;
        #1;
        check_val("drain_busy", busy, 1);
        check_val("drain_app_en", app_en, 0);
        check_val("drain_app_cmd", app_cmd, 3'b001);
        early = 1'b0;
        for (int c = 0; c < 30; c++) begin
            app_rd_data_valid = ((c % 5) == 4);
            step();
            if (c < 29 && (rd_done || wr_ack || !busy)) early = 1'b1;
        end
        app_rd_data_valid = 1'b0;
        check_val("drain_no_early_done", early, 0);
        check_val("drain_rd_done", rd_done, 1);
        check_val("drain_idle", busy, 0);
        check_val("drain_wr_waits", wr_ack, 0);
        step();
        check_val("queued_wr_ack", wr_ack, 1);
        check_val("rd_done_one_cycle", rd_done, 0);
        wr_req = 1'b0;
        rd_app_en = 1'b0;
        run_wr_burst(28'h400);

        // Read where all beats precede rd_ctrl_done
        rd_req = 1'b1; rd_req_len = 16'd4;
        wait_ack(gw, gr);
        rd_req = 1'b0;
        check_val("len4_rd_ack", rd_ack, 1);
        run_rd_burst(4);

        // Zero-length write
        wr_req = 1'b1; wr_req_len = 16'd0;
        wait_ack(gw, gr);
        wr_req = 1'b0;
        check_val("zero_wr_ack", wr_ack, 1);
        check_val("zero_no_start", wr_start, 0);
        check_val("zero_busy0", busy, 0);
        step();
        check_val("zero_wr_done", wr_done, 1);
        check_val("zero_ack_gone", wr_ack, 0);
        check_val("zero_busy1", busy, 0);
        step();
        check_val("zero_done_gone", wr_done, 0);

        // Reset in RD_DRAIN, then stray beats
        rd_req = 1'b1; rd_req_len = 16'd8; rd_req_addr = 28'h500;
        wait_ack(gw, gr);
        rd_req = 1'b0;
        app_rd_data_valid = 1'b1;
        step();
        rd_ctrl_done = 1'b1;
        step();
        rd_ctrl_done = 1'b0;
        app_rd_data_valid = 1'b0;
        check_val("pre_rst_drain_cmd", app_cmd, 3'b001);
        check_val("pre_rst_busy", busy, 1);
        check_val("pre_rst_stray", stray_rd_err, 0);
        #1;
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_app_cmd", app_cmd, 0);
        check_val("mid_rst_app_en", app_en, 0);
        check_val("mid_rst_rd_addr", rd_start_addr, 0);
        check_val("mid_rst_rd_len", rd_start_len, 0);
        check_val("mid_rst_rd_done", rd_done, 0);
        step();
        rst = 1'b0;
        step();
        app_rd_data_valid = 1'b1;
        step();
        app_rd_data_valid = 1'b0;
        check_val("stray_set", stray_rd_err, 1);
        repeat (5) step();
        check_val("stray_sticky", stray_rd_err, 1);
        do_reset();
        check_val("stray_cleared", stray_rd_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mig_rw_arbiter.md
Name: mig_rw_arbiter

Overview:
- Shares the single MIG user interface (app_addr/app_cmd/app_en) between one write burst controller and one read burst controller.
- Accepts burst requests from a write client and a read client and arbitrates round-robin. It starts the selected sub-controller, muxes its app command signals onto the MIG, and reports completion.
- A read burst completes only after every requested data beat has returned.
- Sits between the frame/pixel clients and the per-direction MIG controllers, in the ui_clk domain.

Parameters:
- ADDR_W, 28, MIG app address width.
- LEN_W, 16, burst length width in 128-bit beats.

Ports:
- ui_clk  in  1  MIG user clock; all logic is synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- init_calib_complete  in  1  no grant is issued while this is low.
- wr_req / rd_req  in  1 each  client request level, held until the matching ack.
- wr_req_addr / rd_req_addr  in  ADDR_W each  burst start address, sampled in the grant cycle.
- wr_req_len / rd_req_len  in  LEN_W each  burst length in beats, sampled in the grant cycle.
- wr_ack / rd_ack  out  1 each  1-cycle pulse: request accepted.
- wr_done / rd_done  out  1 each  1-cycle pulse: burst fully complete.
- wr_start / rd_start  out  1 each  1-cycle start pulse to the sub-controller.
- wr_start_addr / rd_start_addr  out  ADDR_W each  latched start address.
- wr_start_len / rd_start_len  out  LEN_W each  latched length.
- wr_ctrl_done / rd_ctrl_done  in  1 each  sub-controller pulse: last command accepted.
- wr_app_addr / rd_app_addr  in  ADDR_W each  sub-controller command address.
- wr_app_cmd / rd_app_cmd  in  3 each  sub-controller command.
- wr_app_en / rd_app_en  in  1 each  sub-controller command enable.
- app_addr  out  ADDR_W  muxed to the MIG.
- app_cmd  out  3  muxed to the MIG.
- app_en  out  1  muxed to the MIG.
- app_rd_data_valid  in  1  MIG read beat strobe.
- busy  out  1  high in every state except IDLE.
- stray_rd_err  out  1  sticky: a read beat arrived outside a read burst.

Behaviour:
- Reset values: state IDLE; all pulses 0; all latched address/length registers 0; app_en 0; app_cmd 3'b000; stray_rd_err 0; last_grant = RD, so write wins the first tie.
- State machine states: IDLE, WR_RUN, RD_RUN, RD_DRAIN.
- IDLE, grant rule: a grant is issued only when init_calib_complete is 1.
  - If only one request is active, that client wins.
  - If both are active, the client opposite to last_grant wins.
- IDLE, grant cycle N (registered outputs, visible in cycle N+1):
  - x_ack=1 and x_start=1 for exactly one cycle.
  - x_start_addr/len capture the request values.
  - last_grant is updated to the winner.
  - The state moves to WR_RUN or RD_RUN.
- Zero-length request: x_ack in N+1 and x_done in N+2; no x_start; the state stays IDLE; last_grant is still updated.
- WR_RUN: app_* = wr_app_*. On wr_ctrl_done, the state goes to IDLE and wr_done pulses in the next cycle.
- RD_RUN: app_* = rd_app_*. The beat counter (LEN_W bits, cleared at grant) increments on each app_rd_data_valid.
  - On rd_ctrl_done, the state goes to RD_DRAIN.
  - If all beats have already been counted in that same cycle, the state goes directly to IDLE and rd_done pulses.
- RD_DRAIN: app_en=0 and app_cmd=3'b001. The counter keeps counting. When count+valid reaches the latched length, the state goes to IDLE and rd_done pulses next cycle.
- IDLE app outputs: app_en=0 and app_addr holds its last value.
- Turnaround: every burst returns through IDLE, so there is at least one idle cycle between bursts and no back-to-back command overlap.
- app_en from the non-selected controller is ignored and never reaches the MIG.
- app_rd_data_valid in IDLE or WR_RUN sets stray_rd_err. It is cleared only by rst.
- A request that drops before its ack is simply not granted; no error is raised.
- x_ctrl_done arriving in the wrong state is ignored.
- Reset asserted mid-burst: immediate return to IDLE and all outputs to reset values. The sub-controllers are reset by the same rst.
- Beat counter overflow cannot occur because the length is at most 2^LEN_W-1.

Optional Feature:
- Macro: MIG_ARB_RD_PRIORITY_EN.
- Defined: fixed priority, read wins whenever both requests are active in IDLE (display read path protected); last_grant is still tracked but unused.
- Undefined: round-robin as described above.

Test Plan:
- init_calib_complete=0 with wr_req=1 for 20 cycles -> no wr_ack. Raise calib -> wr_ack and wr_start one cycle later, with wr_start_addr = request address (e.g. 0x0000100) and wr_start_len = 64.
- wr_req and rd_req asserted together from reset, 3 bursts each, len 8 -> grant order W,R,W,R,W,R; app_en sourced only from the granted controller; at least one idle cycle between bursts.
- Read len=16, rd_ctrl_done at beat 10, remaining 6 valid beats spread over 30 cycles -> state RD_DRAIN; rd_done pulses exactly one cycle after the 16th beat; a queued wr_req is granted only after that.
- Read len=4 with all 4 beats counted before rd_ctrl_done -> rd_done one cycle after rd_ctrl_done; no RD_DRAIN cycles.
- wr_req_len=0 -> wr_ack then wr_done on consecutive cycles; no wr_start; busy stays 0.
- rst pulsed during RD_DRAIN -> outputs at reset values, state IDLE. Then app_rd_data_valid=1 in IDLE -> stray_rd_err=1, held until the next rst. With MIG_ARB_RD_PRIORITY_EN defined, simultaneous requests -> read granted every time.
